// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, requester indices and one-hot helper for serial_bus_arbiter
package bus_pkg;
  typedef enum logic [2:0] {IDLE, TX_HI, TX_LO, RX_HI, RX_LO} bus_state_t;
  localparam int NUM_REQ = 4;
  localparam int REQ_PC = 0;
  localparam int REQ_MAR = 1;
  localparam int REQ_MDR_TX = 2;
  localparam int REQ_MDR_RX = 3;
  function automatic logic [1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational 4-way round-robin (req, last_idx = last served) -> one-hot gnt, first set bit after last_idx
module rr_arbiter
  import bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_idx,
  output logic [NUM_REQ-1:0] gnt
);
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req[2'(int'(last_idx) + i)]) gnt = NUM_REQ'(1) << 2'(int'(last_idx) + i);
  end
endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin arbiter serialising 16-bit words over an 8-bit host link (req/word_* in, grant/done/out_bus/bus_*/rx_word/rx_valid/busy/error out)
module serial_bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [15:0]         word_pc,
  input  logic [15:0]         word_mar,
  input  logic [15:0]         word_mdr,
  input  logic                ard_receive_ready,
  input  logic                ard_data_ready,
  input  logic [7:0]          in_bus,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  done,
  output logic [7:0]          out_bus,
  output logic                bus_pc,
  output logic                bus_mar,
  output logic                bus_mdr,
  output logic [15:0]         rx_word,
  output logic                rx_valid,
  output logic                busy,
  output logic                error
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  bus_state_t state_q, state_d;
  logic [15:0] hold_q, hold_d, rx_word_q, rx_word_d;
  logic [7:0] rx_hi_q, rx_hi_d, out_bus_q, out_bus_d;
  logic [1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, arb_gnt;
  logic [2:0] sel_q, sel_d;
  logic rx_valid_q, rx_valid_d, error_q, error_d, busy_q;
  logic tx, rx, hs, start, fin, tmo;
  rr_arbiter u_arb (.req(req), .last_idx(last_q), .gnt(arb_gnt));
  assign tx = state_q == TX_HI || state_q == TX_LO;
  assign rx = state_q == RX_HI || state_q == RX_LO;
  assign hs = tx ? ard_receive_ready : rx ? ard_data_ready : 1'b0;
  assign start = state_q == IDLE && |req;
  assign fin = hs && (state_q == TX_LO || state_q == RX_LO);
  // a strobe in the last allowed cycle still completes the byte
  assign tmo = TIMEOUT_CYCLES != 0 && (tx || rx) && !hs && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = tmo ? IDLE : start ? (arb_gnt[REQ_MDR_RX] ? RX_HI : TX_HI) : !hs ? state_q :
              state_q == TX_HI ? TX_LO : state_q == RX_HI ? RX_LO : IDLE;
    grant_d = start ? arb_gnt : (fin || tmo) ? '0 : grant_q;
    hold_d = !start || arb_gnt[REQ_MDR_RX] ? hold_q : arb_gnt[REQ_PC] ? word_pc :
             arb_gnt[REQ_MAR] ? word_mar : word_mdr;
    last_d = (fin || tmo) ? oh2idx(grant_q) : last_q;
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
    rx_hi_d = state_q == RX_HI && hs ? in_bus : rx_hi_q;
    rx_valid_d = state_q == RX_LO && hs;
    rx_word_d = rx_valid_d ? {rx_hi_q, in_bus} : rx_word_q;
    done_d = fin ? grant_q : '0;
    error_d = tmo;
    // outputs are registered from next-state values so they line up with the state they describe
    out_bus_d = state_d == TX_HI ? hold_d[15:8] : state_d == TX_LO ? hold_d[7:0] : 8'h00;
    sel_d = state_d == TX_HI || state_d == TX_LO ? grant_d[2:0] : 3'b000;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      rx_word_q <= '0;
      rx_hi_q <= '0;
      out_bus_q <= '0;
      last_q <= 2'd3;
      cnt_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      sel_q <= '0;
      rx_valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      rx_word_q <= rx_word_d;
      rx_hi_q <= rx_hi_d;
      out_bus_q <= out_bus_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      done_q <= done_d;
      sel_q <= sel_d;
      rx_valid_q <= rx_valid_d;
      error_q <= error_d;
      busy_q <= state_d != IDLE;
    end
  end
  assign grant = grant_q;
  assign done = done_q;
  assign out_bus = out_bus_q;
  assign {bus_mdr, bus_mar, bus_pc} = sel_q;
  assign rx_word = rx_word_q;
  assign rx_valid = rx_valid_q;
  assign busy = busy_q;
  assign error = error_q;
endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Sequences every transfer on the shared 8-bit Arduino link between the CPU core and the host. It round-robin arbitrates four requesters: PC, MAR and MDR word sends, plus MDR word receives. It serialises each granted 16-bit word as two bytes, MSB first, under the `ard_receive_ready`/`ard_data_ready` handshakes. It drives the `bus_pc`/`bus_mar`/`bus_mdr` one-hot selects and `out_bus` that the core exposes.

## Interface
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for one byte handshake; 0 disables the timeout.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: bit 0 PC send, bit 1 MAR send, bit 2 MDR send, bit 3 MDR receive; level-held until `done`.
- `word_pc`, `word_mar`, `word_mdr` in 16 each: send data, sampled at grant.
- `ard_receive_ready` in 1: host consumed the byte currently on `out_bus`; one strobe per byte.
- `ard_data_ready` in 1: host has placed a valid byte on `in_bus`.
- `in_bus` in 8: receive byte.
- `grant` out 4: one-hot, high for the whole transfer.
- `done` out 4: one-cycle pulse on the served bit when its transfer completes.
- `out_bus` out 8: send byte.
- `bus_pc`, `bus_mar`, `bus_mdr` out 1 each: one-hot source select, high during that source's send states only.
- `rx_word` out 16: last received word, held until the next receive completes.
- `rx_valid` out 1: one-cycle pulse, coincident with `done[3]`.
- `busy` out 1: state != IDLE.
- `error` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE, TX_HI, TX_LO, RX_HI, RX_LO.
- IDLE with any `req` bit set:
  - The round-robin arbiter picks the first set bit after the last-served index. After reset the last-served index is 3, so PC has first priority.
  - Latch `grant`. For a send, latch the selected word into a 16-bit holding register.
  - Go to TX_HI for a send or RX_HI for a receive.
- TX_HI:
  - `out_bus` = hold[15:8]; the matching `bus_*` select is high.
  - `ard_receive_ready` moves to TX_LO.
- TX_LO:
  - `out_bus` = hold[7:0].
  - `ard_receive_ready` goes to IDLE, pulses `done`, clears `grant`, and updates the last-served index.
- RX_HI: `ard_data_ready` captures `in_bus` into `rx_word[15:8]` staging and moves to RX_LO.
- RX_LO:
  - `ard_data_ready` captures `in_bus` into [7:0] and goes to IDLE.
  - `rx_word` updates with the full word, and `rx_valid` and `done[3]` pulse.
- Timeout:
  - A per-byte counter resets on every state entry and increments while waiting.
  - Reaching `TIMEOUT_CYCLES` forces IDLE with an `error` pulse and no `done`.
  - `rx_word` is unchanged, and the last-served index still advances.
- Inputs that are ignored:
  - A `req` drop mid-transfer is ignored; the transfer completes with the latched word.
  - `ard_data_ready` during TX states is ignored.
  - `ard_receive_ready` during RX states and in IDLE is ignored.
- `out_bus` is 0 and all selects are 0 outside TX states.

## Timing
- All outputs are registered.
- Reset values: `grant`=0, `done`=0, `out_bus`=0, all `bus_*`=0, `rx_word`=0, `rx_valid`=0, `busy`=0, `error`=0; state is IDLE.
- A `req` seen in IDLE at cycle 0 gives `grant`, `busy`, select and high byte valid at cycle 1.
- A handshake strobe sampled at cycle k advances the state at k+1.
- With strobes on consecutive cycles, the minimum request-to-`done` time is 3 cycles.
- `done` rises in the same cycle the state re-enters IDLE.
- Arbitration runs in that IDLE cycle, so back-to-back words cost 3 cycles each. A requester that keeps `req` high through `done` is re-served only after the other pending requesters.
- A handshake held high across both bytes consumes both bytes on successive cycles.
- Reset asserted mid-transfer aborts immediately: no `done`, no `error`, outputs return to reset values.

## Structure
- Package `bus_pkg`:
  - `bus_state_t` enum.
  - Requester index constants `REQ_PC=0`, `REQ_MAR=1`, `REQ_MDR_TX=2`, `REQ_MDR_RX=3`.
  - `NUM_REQ=4`.
- Sub-module `rr_arbiter`: purely combinational 4-way round-robin. Inputs are `req` and the last-served index; output is a one-hot grant. The last-served register lives in the parent.

## Test plan
- Single PC send: reset; `req`=0001, `word_pc`=16'hA55A; `ard_receive_ready` pulses at cycles 3 and 6 → `out_bus`=8'hA5 with `bus_pc` high in cycles 1-3, 8'h5A in 4-6, `done[0]` at cycle 7.
- Round-robin: `req`=0111 held with ready strobed continuously → service order PC, MAR, MDR, PC, each 3 cycles, no select overlap.
- Receive: `req`=1000; `in_bus`=8'h12 with `ard_data_ready`, then 8'h34 with `ard_data_ready` → `rx_word`=16'h1234, `rx_valid` and `done[3]` pulse together, no `bus_*` asserted.
- Timeout: `TIMEOUT_CYCLES`=8, MAR send with no ready → `error` pulse 8 cycles after TX_HI entry, state IDLE, no `done[1]`, next `req`=0100 granted MDR.
- Reset mid-transfer: assert `rst` during TX_LO → all outputs 0 at once, no `done`; after release, pending `req`=0010 starts fresh from the high byte.
- Ignored inputs: `ard_data_ready` strobes during TX_HI and `ard_receive_ready` in IDLE → no state change, `rx_word` unchanged.
